// File: rtl/updslow_pkg.sv
// Shared constants for the IQ/noise packer: lane geometry, FSM state
// encoding and the expected-noise-count helper.
package updslow_pkg;

  localparam int LANE_W         = 16;
  localparam int LANES_PER_WORD = 8;
  localparam int RES_PER_WORD   = 4;
  localparam int WORD_W         = LANE_W * LANES_PER_WORD;

  typedef logic [LANE_W-1:0] lane_t;

  // Packer FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Number of noise samples a user contributes: ceil(re_amounts / rate),
  // where a rate of zero behaves like one noise sample per RE.
  function automatic logic [15:0] noise_count(input logic [15:0] re_amounts,
                                              input logic [15:0] rate);
    logic [16:0] eff_rate;
    logic [16:0] num;
    eff_rate = (rate == 16'd0) ? 17'd1 : {1'b0, rate};
    num      = {1'b0, re_amounts} + eff_rate - 17'd1;
    return 16'(num / eff_rate);
  endfunction

endpackage

// File: rtl/updslow_lane_packer.sv
// Generic word accumulator: collects items of LANES_PER_ITEM lanes into an
// 8-lane word from lane 0 upward, hands complete words to a one-word holding
// register that drains into a FIFO, and zero-pads a partial word on flush.
module updslow_lane_packer
  import updslow_pkg::*;
#(
  parameter int LANES_PER_ITEM = 1
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             in_accept,
  input  logic [LANE_W*LANES_PER_ITEM-1:0] in_data,
  input  logic                             flush,
  input  logic                             fifo_full,
  output logic                             can_accept,
  output logic                             empty,
  output logic                             wr_en,
  output logic [WORD_W-1:0]                wdata
);

  localparam int ITEM_W = LANE_W * LANES_PER_ITEM;
  localparam int ITEMS  = LANES_PER_WORD / LANES_PER_ITEM;
  localparam int CNT_W  = (ITEMS > 1) ? $clog2(ITEMS) : 1;

  logic [CNT_W-1:0]  item_cnt_reg;
  logic [WORD_W-1:0] acc_reg;
  logic [WORD_W-1:0] hold_data_reg;
  logic              hold_valid_reg;

  logic              retire;
  logic              hold_free;
  logic              partial;
  logic              word_done;
  logic              flush_move;
  logic [WORD_W-1:0] word_next;

  // The word as it looks once the incoming item lands in its slot; this is
  // what gets captured when the last slot is filled.
  for (genvar gi = 0; gi < ITEMS; gi++) begin : g_slot
    assign word_next[gi*ITEM_W +: ITEM_W] =
      (CNT_W'(gi) == item_cnt_reg) ? in_data : acc_reg[gi*ITEM_W +: ITEM_W];
  end

  assign retire     = hold_valid_reg && !fifo_full;
  assign hold_free  = !hold_valid_reg || retire;
  assign partial    = (item_cnt_reg != '0);
  assign word_done  = in_accept && (item_cnt_reg == CNT_W'(ITEMS - 1));
  assign flush_move = flush && partial && hold_free;

  // Stall upstream only while a held word is stuck behind a full FIFO.
  assign can_accept = hold_free;
  assign empty      = !partial && !hold_valid_reg;
  assign wr_en      = retire;
  assign wdata      = hold_data_reg;

  // Accumulator: slots fill in order and clear once the word leaves, so
  // unused lanes of a flushed partial word are already zero.
  always_ff @(posedge clk) begin
    if (srst || word_done || flush_move) begin
      acc_reg      <= '0;
      item_cnt_reg <= '0;
    end else if (in_accept) begin
      for (int s = 0; s < ITEMS; s++) begin
        if (CNT_W'(s) == item_cnt_reg) begin
          acc_reg[s*ITEM_W +: ITEM_W] <= in_data;
        end
      end
      item_cnt_reg <= item_cnt_reg + CNT_W'(1);
    end
  end

  // Holding register: loaded by a completed or flushed word, emptied when
  // the FIFO takes it; data is kept after retirement so wdata never glitches.
  always_ff @(posedge clk) begin
    if (srst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (word_done) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= word_next;
    end else if (flush_move) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= acc_reg;
    end else if (retire) begin
      hold_valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/updslow_iq_packer.sv
// Per-user IQ and noise packer: latches the user's RE count and noise rate,
// accepts exactly that many REs and ceil(REs/rate) noise samples, packs them
// into 128-bit FIFO words and flushes partial words before signalling done.
module updslow_iq_packer
  import updslow_pkg::*;
(
  input  logic          i_core_clk,
  input  logic          i_rx_rst,
  input  logic          i_user_start,
  input  logic [15:0]   i_cur_user_re_amounts,
  input  logic [15:0]   i_user_iq_noise_rate,
  input  logic          i_re_valid,
  input  logic [15:0]   i_re_data_i,
  input  logic [15:0]   i_re_data_q,
  input  logic          i_noise_valid,
  input  logic [15:0]   i_noise_data,
  output logic          o_re_ready,
  output logic          o_noise_ready,
  output logic          o_iq_fifo_wr_en,
  output logic [127:0]  o_iq_fifo_wdata,
  input  logic          i_iq_fifo_full,
  output logic          o_noise_fifo_wr_en,
  output logic [127:0]  o_noise_fifo_wdata,
  input  logic          i_noise_fifo_full,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_overflow
);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [15:0] re_target_reg;
  logic [15:0] noise_target_reg;
  logic [15:0] re_cnt_reg;
  logic [15:0] noise_cnt_reg;
  logic        overflow_reg;

  logic        in_run;
  logic        in_flush;
  logic        start_user;
  logic        re_complete;
  logic        noise_complete;
  logic        re_accept;
  logic        noise_accept;
  logic        iq_can_accept;
  logic        noise_can_accept;
  logic        iq_empty;
  logic        noise_empty;

  assign in_run         = (state_reg == ST_RUN);
  assign in_flush       = (state_reg == ST_FLUSH);
  assign start_user     = (state_reg == ST_IDLE) && i_user_start;
  assign re_complete    = (re_cnt_reg == re_target_reg);
  assign noise_complete = (noise_cnt_reg == noise_target_reg);

  assign o_re_ready    = in_run && !re_complete && iq_can_accept;
  assign o_noise_ready = in_run && !noise_complete && noise_can_accept;
  assign re_accept     = i_re_valid && o_re_ready;
  assign noise_accept  = i_noise_valid && o_noise_ready;

  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = (state_reg == ST_DONE);
  assign o_overflow = overflow_reg;

  // IQ path: one RE (I in the low lane, Q above it) fills two lanes.
  updslow_lane_packer #(
    .LANES_PER_ITEM (2)
  ) u_iq_packer (
    .clk        (i_core_clk),
    .srst       (i_rx_rst),
    .in_accept  (re_accept),
    .in_data    ({i_re_data_q, i_re_data_i}),
    .flush      (in_flush),
    .fifo_full  (i_iq_fifo_full),
    .can_accept (iq_can_accept),
    .empty      (iq_empty),
    .wr_en      (o_iq_fifo_wr_en),
    .wdata      (o_iq_fifo_wdata)
  );

  // Noise path: one sample per lane.
  updslow_lane_packer #(
    .LANES_PER_ITEM (1)
  ) u_noise_packer (
    .clk        (i_core_clk),
    .srst       (i_rx_rst),
    .in_accept  (noise_accept),
    .in_data    (i_noise_data),
    .flush      (in_flush),
    .fifo_full  (i_noise_fifo_full),
    .can_accept (noise_can_accept),
    .empty      (noise_empty),
    .wr_en      (o_noise_fifo_wr_en),
    .wdata      (o_noise_fifo_wdata)
  );

  // Next-state logic: RUN until both streams are fully accepted, FLUSH until
  // both paths have drained, then a single DONE cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_user_start) state_next = ST_RUN;
      ST_RUN:   if (re_complete && noise_complete) state_next = ST_FLUSH;
      ST_FLUSH: if (iq_empty && noise_empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // User targets are latched on start; accept counters track progress.
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      re_target_reg    <= '0;
      noise_target_reg <= '0;
      re_cnt_reg       <= '0;
      noise_cnt_reg    <= '0;
    end else if (start_user) begin
      re_target_reg    <= i_cur_user_re_amounts;
      noise_target_reg <= noise_count(i_cur_user_re_amounts, i_user_iq_noise_rate);
      re_cnt_reg       <= '0;
      noise_cnt_reg    <= '0;
    end else begin
      if (re_accept) re_cnt_reg <= re_cnt_reg + 16'd1;
      if (noise_accept) noise_cnt_reg <= noise_cnt_reg + 16'd1;
    end
  end

  // Sticky overflow: upstream offered data that this block refused in RUN.
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      overflow_reg <= 1'b0;
    end else if (in_run && ((i_re_valid && !o_re_ready) ||
                            (i_noise_valid && !o_noise_ready))) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_updslow_iq_packer.sv
// Directed bench for updslow_iq_packer: drivers push expected FIFO words to
// scoreboard queues as samples are accepted; a monitor pops and compares.
module tb_updslow_iq_packer;

  logic         tb_sclk = 1'b0;
  logic         i_rx_rst = 1'b1;
  logic         i_user_start = 1'b0;
  logic [15:0]  i_cur_user_re_amounts = '0;
  logic [15:0]  i_user_iq_noise_rate = '0;
  logic         i_re_valid = 1'b0;
  logic [15:0]  i_re_data_i = '0;
  logic [15:0]  i_re_data_q = '0;
  logic         i_noise_valid = 1'b0;
  logic [15:0]  i_noise_data = '0;
  logic         o_re_ready;
  logic         o_noise_ready;
  logic         o_iq_fifo_wr_en;
  logic [127:0] o_iq_fifo_wdata;
  logic         i_iq_fifo_full = 1'b0;
  logic         o_noise_fifo_wr_en;
  logic [127:0] o_noise_fifo_wdata;
  logic         i_noise_fifo_full = 1'b0;
  logic         o_busy;
  logic         o_done;
  logic         o_overflow;

  int errors = 0;
  int checks = 0;
  logic [127:0] iq_q[$];
  logic [127:0] noise_q[$];
  int iq_wr_cnt = 0;
  int noise_wr_cnt = 0;
  int done_cnt = 0;
  logic [127:0] first_iq_word = '0;
  logic [127:0] last_iq_word = '0;
  logic [127:0] last_noise_word = '0;
  bit first_iq_seen = 1'b0;

  always #5 tb_sclk = ~tb_sclk;

  updslow_iq_packer dut (
    .i_core_clk            (tb_sclk),
    .i_rx_rst              (i_rx_rst),
    .i_user_start          (i_user_start),
    .i_cur_user_re_amounts (i_cur_user_re_amounts),
    .i_user_iq_noise_rate  (i_user_iq_noise_rate),
    .i_re_valid            (i_re_valid),
    .i_re_data_i           (i_re_data_i),
    .i_re_data_q           (i_re_data_q),
    .i_noise_valid         (i_noise_valid),
    .i_noise_data          (i_noise_data),
    .o_re_ready            (o_re_ready),
    .o_noise_ready         (o_noise_ready),
    .o_iq_fifo_wr_en       (o_iq_fifo_wr_en),
    .o_iq_fifo_wdata       (o_iq_fifo_wdata),
    .i_iq_fifo_full        (i_iq_fifo_full),
    .o_noise_fifo_wr_en    (o_noise_fifo_wr_en),
    .o_noise_fifo_wdata    (o_noise_fifo_wdata),
    .i_noise_fifo_full     (i_noise_fifo_full),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_overflow            (o_overflow)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every FIFO write is compared against the queue head.
  task automatic monitor();
    forever begin
      @(negedge tb_sclk);
      if (o_iq_fifo_wr_en === 1'b1) begin
        iq_wr_cnt++;
        if (!first_iq_seen) begin
          first_iq_word = o_iq_fifo_wdata;
          first_iq_seen = 1'b1;
        end
        last_iq_word = o_iq_fifo_wdata;
        check("iq_wr_while_full", 128'(i_iq_fifo_full), 128'(0));
        check("iq_expected_pending", 128'(iq_q.size() != 0), 128'(1));
        if (iq_q.size() != 0) check("iq_word", o_iq_fifo_wdata, iq_q.pop_front());
      end
      if (o_noise_fifo_wr_en === 1'b1) begin
        noise_wr_cnt++;
        last_noise_word = o_noise_fifo_wdata;
        check("noise_wr_while_full", 128'(i_noise_fifo_full), 128'(0));
        check("noise_expected_pending", 128'(noise_q.size() != 0), 128'(1));
        if (noise_q.size() != 0) check("noise_word", o_noise_fifo_wdata, noise_q.pop_front());
      end
      if (o_done === 1'b1) done_cnt++;
    end
  endtask

  task automatic start_user(input int re, input int rate);
    @(negedge tb_sclk);
    i_user_start = 1'b1;
    i_cur_user_re_amounts = 16'(re);
    i_user_iq_noise_rate = 16'(rate);
    @(posedge tb_sclk);
    #1;
    i_user_start = 1'b0;
  endtask

  // Sends n REs (valid only raised while ready is high) and builds the
  // expected IQ words; the partial last word is queued only if push_partial.
  task automatic send_res(input int n, input int base, input bit push_partial);
    logic [127:0] w;
    int slot;
    int guard;
    logic [15:0] di;
    logic [15:0] dq;
    w = '0;
    slot = 0;
    for (int k = 0; k < n; k++) begin
      di = 16'(base + k);
      dq = 16'(32'h100 + base + k);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge tb_sclk);
        #1;
      end
      guard = 0;
      @(negedge tb_sclk);
      while (!o_re_ready && guard < 400) begin
        @(negedge tb_sclk);
        guard++;
      end
      if (!o_re_ready) begin
        check("re_ready_timeout", 128'(o_re_ready), 128'(1));
        return;
      end
      i_re_valid = 1'b1;
      i_re_data_i = di;
      i_re_data_q = dq;
      @(posedge tb_sclk);
      #1;
      i_re_valid = 1'b0;
      w[slot*32 +: 32] = {dq, di};
      slot++;
      if (slot == 4) begin
        iq_q.push_back(w);
        w = '0;
        slot = 0;
      end
    end
    if (slot != 0 && push_partial) iq_q.push_back(w);
  endtask

  task automatic send_noise(input int n, input int base, input int pace);
    logic [127:0] w;
    int slot;
    int guard;
    logic [15:0] d;
    w = '0;
    slot = 0;
    for (int k = 0; k < n; k++) begin
      d = 16'(32'h8000 + base + k);
      guard = 0;
      @(negedge tb_sclk);
      while (!o_noise_ready && guard < 400) begin
        @(negedge tb_sclk);
        guard++;
      end
      if (!o_noise_ready) begin
        check("noise_ready_timeout", 128'(o_noise_ready), 128'(1));
        return;
      end
      i_noise_valid = 1'b1;
      i_noise_data = d;
      @(posedge tb_sclk);
      #1;
      i_noise_valid = 1'b0;
      w[slot*16 +: 16] = d;
      slot++;
      if (slot == 8) begin
        noise_q.push_back(w);
        w = '0;
        slot = 0;
      end
      repeat (pace - 1) @(posedge tb_sclk);
    end
    if (slot != 0) noise_q.push_back(w);
  endtask

  // Holds the noise FIFO full for 40 cycles: no writes may happen, ready
  // must drop once a word is held, and the held data must not change.
  task automatic stall_noise();
    bit low_seen;
    bit stable;
    bit captured;
    int stall_writes;
    logic [127:0] held;
    low_seen = 1'b0;
    stable = 1'b1;
    captured = 1'b0;
    stall_writes = 0;
    held = '0;
    repeat (10) @(posedge tb_sclk);
    #1;
    i_noise_fifo_full = 1'b1;
    repeat (40) begin
      @(negedge tb_sclk);
      if (o_noise_fifo_wr_en) stall_writes++;
      if (!o_noise_ready) begin
        low_seen = 1'b1;
        if (!captured) begin
          held = o_noise_fifo_wdata;
          captured = 1'b1;
        end else if (o_noise_fifo_wdata !== held) begin
          stable = 1'b0;
        end
      end
    end
    @(posedge tb_sclk);
    #1;
    i_noise_fifo_full = 1'b0;
    check("stall_noise_ready_low", 128'(low_seen), 128'(1));
    check("stall_noise_writes", 128'(stall_writes), 128'(0));
    check("stall_noise_wdata_stable", 128'(stable), 128'(1));
  endtask

  task automatic finish_user(input string tag, input int exp_iq, input int exp_nz,
                             input int iq0, input int nz0, input int d0);
    int k;
    k = 0;
    while (!o_done && k < 2000) begin
      @(negedge tb_sclk);
      k++;
    end
    check({tag, "_done_seen"}, 128'(o_done), 128'(1));
    repeat (3) @(negedge tb_sclk);
    check({tag, "_iq_words"}, 128'(iq_wr_cnt - iq0), 128'(exp_iq));
    check({tag, "_noise_words"}, 128'(noise_wr_cnt - nz0), 128'(exp_nz));
    check({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'(1));
    check({tag, "_iq_queue_empty"}, 128'(iq_q.size()), 128'(0));
    check({tag, "_noise_queue_empty"}, 128'(noise_q.size()), 128'(0));
    check({tag, "_idle_after_done"}, 128'(o_busy), 128'(0));
    $display("user %s: re_words=%0d noise_words=%0d", tag, iq_wr_cnt - iq0, noise_wr_cnt - nz0);
  endtask

  task automatic run_user(input string tag, input int re, input int rate, input int base,
                          input bit stall, input int pace);
    int eff;
    int nn;
    int iq0;
    int nz0;
    int d0;
    eff = (rate == 0) ? 1 : rate;
    nn = (re + eff - 1) / eff;
    iq0 = iq_wr_cnt;
    nz0 = noise_wr_cnt;
    d0 = done_cnt;
    first_iq_seen = 1'b0;
    start_user(re, rate);
    check({tag, "_busy_after_start"}, 128'(o_busy), 128'(1));
    fork
      send_res(re, base, 1'b1);
      send_noise(nn, base, pace);
      if (stall) stall_noise();
    join
    finish_user(tag, (re + 3) / 4, (nn + 7) / 8, iq0, nz0, d0);
  endtask

  initial begin
    int iq0;
    int nz0;
    int d0;
    int found;

    // Reset state
    repeat (3) @(posedge tb_sclk);
    #1;
    i_rx_rst = 1'b0;
    @(negedge tb_sclk);
    check("reset_busy", 128'(o_busy), 128'(0));
    check("reset_done", 128'(o_done), 128'(0));
    check("reset_overflow", 128'(o_overflow), 128'(0));
    check("reset_re_ready", 128'(o_re_ready), 128'(0));
    check("reset_iq_wr_en", 128'(o_iq_fifo_wr_en), 128'(0));
    check("reset_noise_wr_en", 128'(o_noise_fifo_wr_en), 128'(0));
    fork
      monitor();
    join_none

    // Lane ordering of the first IQ word
    run_user("lanes", 4, 2, 0, 1'b0, 1);
    check("lanes_first_word", first_iq_word,
          128'h0103_0003_0102_0002_0101_0001_0100_0000);

    // 107 REs, rate 6: 27 IQ words and 3 noise words with zero padding
    run_user("u107", 107, 6, 16'h10, 1'b0, 3);
    check("u107_last_iq_pad", 128'(last_iq_word[127:96]), 128'(0));
    check("u107_last_iq_lane5", 128'(last_iq_word[95:80]), 128'(16'h100 + 16'h10 + 106));
    check("u107_last_noise_pad", 128'(last_noise_word[127:32]), 128'(0));
    check("u107_last_noise_lane1", 128'(last_noise_word[31:16]), 128'(16'h8000 + 16'h10 + 17));

    // Noise FIFO held full mid-user
    run_user("stall", 64, 2, 16'h20, 1'b1, 2);

    // Rate zero behaves as one noise sample per RE
    run_user("rate0", 9, 0, 16'h500, 1'b0, 1);

    // Zero REs: straight through, done three cycles after start
    iq0 = iq_wr_cnt;
    nz0 = noise_wr_cnt;
    d0 = done_cnt;
    start_user(0, 5);
    found = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge tb_sclk);
      if (o_done && found == 0) found = c;
    end
    check("zero_done_latency", 128'(found), 128'(3));
    check("zero_iq_words", 128'(iq_wr_cnt - iq0), 128'(0));
    check("zero_noise_words", 128'(noise_wr_cnt - nz0), 128'(0));
    check("zero_done_pulses", 128'(done_cnt - d0), 128'(1));
    $display("user zero: done after %0d cycles", found);

    // Overflow: offer an RE after the count is complete; also a start
    // pulse mid-user that must be ignored
    iq0 = iq_wr_cnt;
    nz0 = noise_wr_cnt;
    d0 = done_cnt;
    start_user(4, 4);
    send_res(4, 16'h40, 1'b1);
    start_user(100, 1);
    @(negedge tb_sclk);
    check("ovf_re_ready_low", 128'(o_re_ready), 128'(0));
    check("ovf_before", 128'(o_overflow), 128'(0));
    i_re_valid = 1'b1;
    i_re_data_i = 16'hdead;
    i_re_data_q = 16'hbeef;
    @(posedge tb_sclk);
    #1;
    i_re_valid = 1'b0;
    @(negedge tb_sclk);
    check("ovf_set", 128'(o_overflow), 128'(1));
    send_noise(1, 16'h70, 1);
    finish_user("ovf", 1, 1, iq0, nz0, d0);
    repeat (5) @(negedge tb_sclk);
    check("ovf_sticky_idle", 128'(o_overflow), 128'(1));

    // Reset after 10 REs: held and partial words discarded
    iq0 = iq_wr_cnt;
    start_user(40, 4);
    send_res(10, 16'h200, 1'b0);
    repeat (3) @(posedge tb_sclk);
    #1;
    check("rst_words_before", 128'(iq_wr_cnt - iq0), 128'(2));
    i_rx_rst = 1'b1;
    @(posedge tb_sclk);
    #1;
    i_rx_rst = 1'b0;
    @(negedge tb_sclk);
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_overflow", 128'(o_overflow), 128'(0));
    check("rst_re_ready", 128'(o_re_ready), 128'(0));
    check("rst_iq_wr_en", 128'(o_iq_fifo_wr_en), 128'(0));
    check("rst_iq_wdata", o_iq_fifo_wdata, 128'(0));
    check("rst_noise_wdata", o_noise_fifo_wdata, 128'(0));
    iq0 = iq_wr_cnt;
    nz0 = noise_wr_cnt;
    repeat (20) @(negedge tb_sclk);
    check("rst_no_iq_writes", 128'(iq_wr_cnt - iq0), 128'(0));
    check("rst_no_noise_writes", 128'(noise_wr_cnt - nz0), 128'(0));
    $display("reset mid-user: outputs cleared");

    // Clean user after reset
    run_user("post_rst", 12, 3, 16'h300, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updslow_iq_packer.md
UPDSLOW_IQ_PACKER -- requirements
Module: updslow_iq_packer

Interface
REQ-001 SHALL have input i_core_clk, 1 bit: single clock; all logic is rising-edge.
REQ-002 SHALL have input i_rx_rst, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have input i_user_start, 1 bit: one-cycle pulse that latches the user parameters and starts packing.
REQ-004 SHALL have input i_cur_user_re_amounts, 16 bits: number of REs for this user.
REQ-005 SHALL have input i_user_iq_noise_rate, 16 bits: REs per noise sample.
REQ-006 SHALL have inputs i_re_valid (1), i_re_data_i (16) and i_re_data_q (16): RE sample stream.
REQ-007 SHALL have inputs i_noise_valid (1) and i_noise_data (16): noise sample stream.
REQ-008 SHALL have outputs o_re_ready (1) and o_noise_ready (1): upstream backpressure.
REQ-009 SHALL have outputs o_iq_fifo_wr_en (1) and o_iq_fifo_wdata (128): IQ FIFO write port.
REQ-010 SHALL have input i_iq_fifo_full (1): IQ FIFO full flag.
REQ-011 SHALL have outputs o_noise_fifo_wr_en (1) and o_noise_fifo_wdata (128): noise FIFO write port.
REQ-012 SHALL have input i_noise_fifo_full (1): noise FIFO full flag.
REQ-013 SHALL have outputs o_busy (1), o_done (1-cycle pulse) and o_overflow (1, sticky).

Function
REQ-014 SHALL use lane k = wdata[16k+15:16k]; IQ word RE n (n=0..3) SHALL place I in lane 2n and Q in lane 2n+1, filled from lane 0 upward.
REQ-015 SHALL pack noise words as 8 samples, sample n in lane n.
REQ-016 SHALL accept an RE only in a cycle with i_re_valid=1 and o_re_ready=1; noise accepted likewise.
REQ-017 SHALL use FSM IDLE -> RUN on i_user_start; RUN -> FLUSH when both expected counts are accepted; FLUSH -> DONE when all pending words are written; DONE -> IDLE after one cycle, pulsing o_done.
REQ-018 SHALL expect a noise count of ceil(re_amounts / rate), with rate 0 treated as 1.
REQ-019 SHALL give each path a 1-word holding register; a completed word moves to the holding register in the cycle its last lane is accepted.
REQ-020 SHALL assert wr_en for a held word in any cycle its FIFO is not full; the word is retired that cycle, giving wr_en one cycle after the last lane is accepted when the FIFO is not full.
REQ-021 SHALL deassert ready when the holding register is occupied and its FIFO is full, or when the path's count is complete, or outside RUN.
REQ-022 SHALL, in FLUSH, zero-pad any partial word in the unused lanes and write it as the final word of that path.
REQ-023 SHALL write exactly ceil(re_amounts/4) IQ words and ceil(noise_count/8) noise words per user.
REQ-024 SHALL treat re_amounts=0 as go directly RUN -> FLUSH -> DONE with no writes.
REQ-025 SHALL set o_overflow when valid=1 while ready=0 in RUN on either path; o_overflow clears only on reset; no data is written on overflow.
REQ-026 SHALL ignore i_user_start outside IDLE.
REQ-027 SHALL hold o_busy=1 in RUN, FLUSH and DONE.
REQ-028 SHALL hold wdata stable while wr_en=0 and the holding register is occupied.

Reset
REQ-029 SHALL, on i_rx_rst=1 at a clock edge, return to IDLE with all outputs 0, counters, lanes and holding registers cleared, and o_overflow cleared.
REQ-030 SHALL, on reset mid-user, discard partial and held words with no flush write.

Structure
REQ-031 SHALL place the lane width (16), lanes per word (8), REs per word (4) and the FSM state encoding in shared package updslow_pkg.
REQ-032 SHALL implement one sub-module, updslow_lane_packer (generic N-lane accumulator + holding register + flush), instantiated twice.

Verification
REQ-033 SHALL check: re_amounts=107, rate=6, no full -> 27 IQ words, last word lanes 6-7 zero; 18 noise samples -> 3 noise words, last word lanes 2-7 zero; o_done once.
REQ-034 SHALL check: REs I=n, Q=0x100+n for n=0..3 -> first wdata lanes = {0x103,3,0x102,2,0x101,1,0x100,0} (lane7..lane0).
REQ-035 SHALL check: i_noise_fifo_full=1 for 40 cycles mid-user -> o_noise_ready low, no noise writes, no loss, resumes with correct order.
REQ-036 SHALL check: re_amounts=0 -> no writes, o_done 3 cycles after start.
REQ-037 SHALL check: i_re_valid=1 while o_re_ready=0 -> o_overflow=1 and stays 1 until reset.
REQ-038 SHALL check: reset asserted after 10 REs -> no further writes, outputs 0 next cycle, a new user starts cleanly.
